// File: rtl/fixed_activation_skid_framer.sv
// Registered 2-entry skid output stage for a fixed-point activation stream, tagging the last beat of each tensor.
// Define ZERO_COUNT_EN to add data_out_0_zeros, the per-tensor count of exactly-zero elements.
module fixed_activation_skid_framer #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    localparam int P = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic signed [DATA_IN_0_PRECISION_0-1:0] data_in_0 [P-1:0],
    input  logic                                    data_in_0_valid,
    output logic                                    data_in_0_ready,
    output logic signed [DATA_IN_0_PRECISION_0-1:0] data_out_0 [P-1:0],
    output logic                                    data_out_0_valid,
    input  logic                                    data_out_0_ready,
`ifdef ZERO_COUNT_EN
    output logic [$clog2(DATA_IN_0_TENSOR_SIZE_DIM_0*DATA_IN_0_TENSOR_SIZE_DIM_1+1)-1:0] data_out_0_zeros,
`endif
    output logic                                    data_out_0_last
);
    localparam int W      = DATA_IN_0_PRECISION_0;
    localparam int BEATS  = (DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0) *
                            (DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if ((DATA_IN_0_TENSOR_SIZE_DIM_0 % DATA_IN_0_PARALLELISM_DIM_0) != 0 ||
        (DATA_IN_0_TENSOR_SIZE_DIM_1 % DATA_IN_0_PARALLELISM_DIM_1) != 0 ||
        DATA_IN_0_PRECISION_1 < 0) begin : g_bad_cfg
        $error("fixed_activation_skid_framer: parallelism must divide tensor size");
    end

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic signed [W-1:0] out_data_q  [P-1:0];
    logic signed [W-1:0] out_data_d  [P-1:0];
    logic signed [W-1:0] skid_data_q [P-1:0];
    logic signed [W-1:0] skid_data_d [P-1:0];
    logic                out_last_q, out_last_d;
    logic                skid_last_q, skid_last_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                in_hs, out_hs, in_last;
    logic                load_in, load_skid, load_from_skid;

    assign in_hs   = data_in_0_valid && ready_q;
    assign out_hs  = valid_q && data_out_0_ready;
    assign in_last = (beat_q == LAST_BEAT);

    // In EMPTY the output slot is free; in ONE it frees only if the current beat leaves.
    assign load_in        = in_hs && (state_q == EMPTY || out_hs);
    assign load_skid      = in_hs && (state_q == ONE) && !out_hs;
    assign load_from_skid = out_hs && (state_q == FULL);

`ifdef ZERO_COUNT_EN
    localparam int CNT_W = $clog2(DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1 + 1);

    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] out_zeros_q, out_zeros_d;
    logic [CNT_W-1:0] skid_zeros_q, skid_zeros_d;
    logic [CNT_W-1:0] zeros_beat, in_zeros;

    always_comb begin
        zeros_beat = '0;
        for (int i = 0; i < P; i++) begin
            if (data_in_0[i] == '0) zeros_beat = zeros_beat + 1'b1;
        end
        in_zeros = in_last ? acc_q + zeros_beat : '0;
        acc_d    = acc_q;
        if (in_hs) acc_d = in_last ? '0 : acc_q + zeros_beat;
        out_zeros_d  = out_zeros_q;
        skid_zeros_d = skid_zeros_q;
        if (load_in)             out_zeros_d  = in_zeros;
        else if (load_from_skid) out_zeros_d  = skid_zeros_q;
        if (load_skid)           skid_zeros_d = in_zeros;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            out_zeros_q  <= '0;
            skid_zeros_q <= '0;
        end else begin
            acc_q        <= acc_d;
            out_zeros_q  <= out_zeros_d;
            skid_zeros_q <= skid_zeros_d;
        end
    end

    assign data_out_0_zeros = out_zeros_q;
`endif

    always_comb begin
        beat_d = beat_q;
        if (in_hs) beat_d = in_last ? '0 : beat_q + 1'b1;

        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        if (load_in) begin
            out_data_d = data_in_0;
            out_last_d = in_last;
        end else if (load_from_skid) begin
            out_data_d = skid_data_q;
            out_last_d = skid_last_q;
        end
        if (load_skid) begin
            skid_data_d = data_in_0;
            skid_last_d = in_last;
        end

        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (in_hs) state_d = ONE;
            ONE:     if (load_skid) state_d = FULL;
                     else if (!in_hs && out_hs) state_d = EMPTY;
            FULL:    if (out_hs) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        valid_d = (state_d != EMPTY);
        ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            out_data_q  <= '{default: '0};
            out_last_q  <= 1'b0;
            skid_data_q <= '{default: '0};
            skid_last_q <= 1'b0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            beat_q      <= beat_d;
        end
    end

    assign data_in_0_ready  = ready_q;
    assign data_out_0_valid = valid_q;
    assign data_out_0       = out_data_q;
    assign data_out_0_last  = out_last_q;
endmodule

// File: tb/tb_fixed_activation_skid_framer.sv
// Bench for fixed_activation_skid_framer: three instances (P=1/BEATS=10, P=2/BEATS=2, P=4/BEATS=1).
module tb_fixed_activation_skid_framer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic signed [7:0] din_a [0:0];
    logic signed [7:0] dout_a [0:0];
    logic vin_a, rdy_a, vld_a, ordy_a, last_a;
    logic signed [7:0] din_b [1:0];
    logic signed [7:0] dout_b [1:0];
    logic vin_b, rdy_b, vld_b, ordy_b, last_b;
    logic signed [7:0] din_c [3:0];
    logic signed [7:0] dout_c [3:0];
    logic vin_c, rdy_c, vld_c, ordy_c, last_c;
`ifdef ZERO_COUNT_EN
    logic [2:0] zer_b, zer_c;
`endif

    int total = 0;
    int bad = 0;

    typedef struct packed { logic signed [7:0] d; logic l; } beat_t;

    fixed_activation_skid_framer #(
        .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(4),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(10), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
        .DATA_IN_0_PARALLELISM_DIM_0(1), .DATA_IN_0_PARALLELISM_DIM_1(1)
    ) u_a (
        .clk(clk), .rst(rst),
        .data_in_0(din_a), .data_in_0_valid(vin_a), .data_in_0_ready(rdy_a),
        .data_out_0(dout_a), .data_out_0_valid(vld_a), .data_out_0_ready(ordy_a),
        .data_out_0_last(last_a)
    );

    fixed_activation_skid_framer #(
        .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(4),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(4), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
        .DATA_IN_0_PARALLELISM_DIM_0(2), .DATA_IN_0_PARALLELISM_DIM_1(1)
    ) u_b (
        .clk(clk), .rst(rst),
        .data_in_0(din_b), .data_in_0_valid(vin_b), .data_in_0_ready(rdy_b),
        .data_out_0(dout_b), .data_out_0_valid(vld_b), .data_out_0_ready(ordy_b),
`ifdef ZERO_COUNT_EN
        .data_out_0_zeros(zer_b),
`endif
        .data_out_0_last(last_b)
    );

    fixed_activation_skid_framer #(
        .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(4),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(4), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
        .DATA_IN_0_PARALLELISM_DIM_0(4), .DATA_IN_0_PARALLELISM_DIM_1(1)
    ) u_c (
        .clk(clk), .rst(rst),
        .data_in_0(din_c), .data_in_0_valid(vin_c), .data_in_0_ready(rdy_c),
        .data_out_0(dout_c), .data_out_0_valid(vld_c), .data_out_0_ready(ordy_c),
`ifdef ZERO_COUNT_EN
        .data_out_0_zeros(zer_c),
`endif
        .data_out_0_last(last_c)
    );

    task automatic do_reset();
        rst = 1'b1;
        vin_a = 1'b0; vin_b = 1'b0; vin_c = 1'b0;
        ordy_a = 1'b1; ordy_b = 1'b1; ordy_c = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vin_a = 1'b0; vin_b = 1'b0; vin_c = 1'b0;
        ordy_a = 1'b1; ordy_b = 1'b1; ordy_c = 1'b1;
        din_a = '{default: '0}; din_b = '{default: '0}; din_c = '{default: '0};
        repeat (2) @(posedge clk); #1;
        total++;
        if (vld_a !== 1'b0 || last_a !== 1'b0 || dout_a[0] !== 8'sd0) begin
            bad++; $display("FAIL reset_a: vld=%b last=%b data=%0d want 0 0 0", vld_a, last_a, dout_a[0]);
        end
        total++;
        if (vld_b !== 1'b0 || last_b !== 1'b0 || vld_c !== 1'b0 || last_c !== 1'b0) begin
            bad++; $display("FAIL reset_bc: vld_b=%b last_b=%b vld_c=%b last_c=%b want all 0", vld_b, last_b, vld_c, last_c);
        end
`ifdef ZERO_COUNT_EN
        total++;
        if (zer_b !== 3'd0 || zer_c !== 3'd0) begin
            bad++; $display("FAIL reset_zeros: b=%0d c=%0d want 0 0", zer_b, zer_c);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rdy_a !== 1'b1) begin bad++; $display("FAIL reset_ready: rdy=%b want 1", rdy_a); end
        for (int i = 1; i <= 4; i++) begin
            vin_a = 1'b1; din_a[0] = 8'(i);
            @(posedge clk); #1;
        end
        vin_a = 1'b0;
        total++;
        if (vld_a !== 1'b1 || dout_a[0] !== 8'sd4) begin
            bad++; $display("FAIL pre_reset: vld=%b data=%0d want 1 4", vld_a, dout_a[0]);
        end
        rst = 1'b1; #1;
        total++;
        if (vld_a !== 1'b0 || last_a !== 1'b0) begin
            bad++; $display("FAIL mid_reset: vld=%b last=%b want 0 0", vld_a, last_a);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rdy_a !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: rdy=%b want 1", rdy_a); end
        for (int i = 0; i < 10; i++) begin
            vin_a = 1'b1; din_a[0] = 8'(100 + i);
            @(posedge clk); #1;
            total++;
            if (vld_a !== 1'b1 || dout_a[0] !== 8'(100 + i) || last_a !== (i == 9)) begin
                bad++; $display("FAIL post_reset_tensor i=%0d: vld=%b data=%0d last=%b want 1 %0d %b",
                                i, vld_a, dout_a[0], last_a, 100 + i, (i == 9));
            end
        end
        vin_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_streaming();
        do_reset();
        vin_a = 1'b1; din_a[0] = 8'sd1;
        @(posedge clk); #1;
        for (int c = 1; c <= 20; c++) begin
            total++;
            if (vld_a !== 1'b1 || dout_a[0] !== 8'(c) || last_a !== (c % 10 == 0)) begin
                bad++; $display("FAIL stream c=%0d: vld=%b data=%0d last=%b want 1 %0d %b",
                                c, vld_a, dout_a[0], last_a, c, (c % 10 == 0));
            end
            if (c < 20) din_a[0] = 8'(c + 1);
            else vin_a = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (vld_a !== 1'b0) begin bad++; $display("FAIL stream_drain: vld=%b want 0", vld_a); end
    endtask

    // Occupancy/queue model: ready <=> fewer than 2 held beats, valid <=> any held beat.
    task automatic test_flow(input bit rnd, input int n_beats, input int max_cyc);
        beat_t q[$];
        int pushed = 0;
        int popped = 0;
        int lasts = 0;
        int cyc = 0;
        logic ihs, ohs;
        do_reset();
        vin_a = 1'b1; ordy_a = 1'b1;
        din_a[0] = rnd ? 8'($urandom) : 8'sd1;
        while ((pushed < n_beats || q.size() > 0) && cyc < max_cyc) begin
            total++;
            if (rdy_a !== (q.size() < 2) || vld_a !== (q.size() > 0)) begin
                bad++; $display("FAIL flow_hs rnd=%0d cyc=%0d: rdy=%b vld=%b want %b %b",
                                rnd, cyc, rdy_a, vld_a, (q.size() < 2), (q.size() > 0));
            end
            if (q.size() > 0) begin
                total++;
                if (dout_a[0] !== q[0].d || last_a !== q[0].l) begin
                    bad++; $display("FAIL flow_data rnd=%0d cyc=%0d: data=%0d last=%b want %0d %b",
                                    rnd, cyc, dout_a[0], last_a, q[0].d, q[0].l);
                end
            end
            ihs = vin_a && (q.size() < 2);
            ohs = ordy_a && (q.size() > 0);
            @(posedge clk); #1;
            cyc++;
            if (ohs) begin
                if (q[0].l) lasts++;
                void'(q.pop_front());
                popped++;
            end
            if (ihs) begin
                q.push_back('{d: din_a[0], l: (pushed % 10 == 9)});
                pushed++;
            end
            if (rnd) begin
                din_a[0] = 8'($urandom);
                vin_a = (pushed < n_beats) && ($urandom_range(0, 3) != 0);
                ordy_a = ($urandom_range(0, 2) != 0);
            end else begin
                din_a[0] = 8'(pushed + 1);
                vin_a = (pushed < n_beats);
                ordy_a = !(cyc >= 5 && cyc <= 7);
            end
        end
        total++;
        if (q.size() != 0 || pushed != n_beats || popped != n_beats || lasts != n_beats / 10) begin
            bad++; $display("FAIL flow_end rnd=%0d: pushed=%0d popped=%0d lasts=%0d want %0d %0d %0d",
                            rnd, pushed, popped, lasts, n_beats, n_beats, n_beats / 10);
        end
        vin_a = 1'b0; ordy_a = 1'b1;
    endtask

    task automatic test_zero_count();
        int v [4][2] = '{'{0, 3}, '{0, 0}, '{5, -1}, '{2, 7}};
        int tz [2];
        do_reset();
        for (int t = 0; t < 2; t++) begin
            tz[t] = 0;
            for (int b = 0; b < 2; b++)
                for (int e = 0; e < 2; e++)
                    if (v[2 * t + b][e] == 0) tz[t]++;
        end
        for (int i = 0; i < 4; i++) begin
            vin_b = 1'b1; din_b[0] = 8'(v[i][0]); din_b[1] = 8'(v[i][1]);
            @(posedge clk); #1;
            total++;
            if (vld_b !== 1'b1 || dout_b[0] !== 8'(v[i][0]) || dout_b[1] !== 8'(v[i][1]) || last_b !== (i % 2 == 1)) begin
                bad++; $display("FAIL p2_beat i=%0d: vld=%b d0=%0d d1=%0d last=%b want 1 %0d %0d %b",
                                i, vld_b, dout_b[0], dout_b[1], last_b, v[i][0], v[i][1], (i % 2 == 1));
            end
`ifdef ZERO_COUNT_EN
            total++;
            if (zer_b !== ((i % 2 == 1) ? 3'(tz[i / 2]) : 3'd0)) begin
                bad++; $display("FAIL p2_zeros i=%0d: zeros=%0d want %0d", i, zer_b, (i % 2 == 1) ? tz[i / 2] : 0);
            end
`endif
        end
        vin_b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        logic signed [7:0] e [4];
        int nz;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            nz = 0;
            for (int k = 0; k < 4; k++) begin
                if (i == 0) e[k] = 8'sd0;
                else if (i == 1 || $urandom_range(0, 1) == 1) e[k] = 8'($urandom_range(1, 255));
                else e[k] = 8'sd0;
                if (e[k] == 8'sd0) nz++;
                din_c[k] = e[k];
            end
            vin_c = 1'b1;
            @(posedge clk); #1;
            total++;
            if (vld_c !== 1'b1 || last_c !== 1'b1 || dout_c[0] !== e[0] || dout_c[1] !== e[1] ||
                dout_c[2] !== e[2] || dout_c[3] !== e[3]) begin
                bad++; $display("FAIL beats1 i=%0d: vld=%b last=%b d=%0d,%0d,%0d,%0d want 1 1 %0d,%0d,%0d,%0d",
                                i, vld_c, last_c, dout_c[0], dout_c[1], dout_c[2], dout_c[3], e[0], e[1], e[2], e[3]);
            end
`ifdef ZERO_COUNT_EN
            total++;
            if (zer_c !== 3'(nz)) begin
                bad++; $display("FAIL beats1_zeros i=%0d: zeros=%0d want %0d", i, zer_c, nz);
            end
`endif
        end
        vin_c = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_flow(1'b0, 12, 200);
        test_flow(1'b1, 1000, 20000);
        test_zero_count();
        test_single_beat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
